// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: Booth row operations,
// the triplet encoder and the controller state encoding.
package booth_r4_pkg;

    typedef enum logic [2:0] {
        ZERO,
        PA,
        P2A,
        NA,
        N2A
    } booth_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_e;

    // Standard radix-4 recoding of {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_op_e booth_enc(input logic [2:0] triplet);
        booth_op_e op;
        case (triplet)
            3'b001, 3'b010: op = PA;
            3'b011:         op = P2A;
            3'b100:         op = N2A;
            3'b101, 3'b110: op = NA;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_pp_row.sv
// Combinational Booth partial-product row: selects 0, +A, +2A, -A or -2A as a
// WIDTH+1-bit value, plus the true sign of that value for sign extension.
module booth_r4_pp_row
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  booth_op_e        op,
    output logic [WIDTH:0]   row,
    output logic             row_neg
);

    logic [WIDTH:0] a_x1;
    logic [WIDTH:0] a_x2;
    logic           a_neg;
    logic           neg_of_a;

    assign a_x1     = {a[WIDTH-1], a};
    assign a_x2     = {a, 1'b0};
    assign a_neg    = a[WIDTH-1];
    assign neg_of_a = ~a[WIDTH-1] & (|a);

    // -2A with A = -2^(W-1) is +2^W, which the WIDTH+1-bit row wraps to the
    // same bit pattern as -2^W; row_neg carries the real sign so the
    // accumulator extends it correctly.
    always_comb begin
        row     = '0;
        row_neg = 1'b0;
        case (op)
            PA: begin
                row     = a_x1;
                row_neg = a_neg;
            end
            P2A: begin
                row     = a_x2;
                row_neg = a_neg;
            end
            NA: begin
                row     = -a_x1;
                row_neg = neg_of_a;
            end
            N2A: begin
                row     = -a_x2;
                row_neg = neg_of_a;
            end
            default: begin
                row     = '0;
                row_neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative signed radix-4 Booth multiplier, one partial-product row per clock.
// Define BOOTH_APPROX_EN to add the trunc_k port and per-row low-column truncation.
module booth_r4_seq_mult
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(2*WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
`ifdef BOOTH_APPROX_EN
    input  logic [KW-1:0]      trunc_k,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
);

    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N);

    mult_state_e          state_reg, state_next;
    logic [CW-1:0]        cnt_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc_reg;

    logic                 accept;
    logic                 last_row;
    logic [WIDTH:0]       b_ext;
    logic [CW:0]          shamt;
    logic [2:0]           triplet;
    booth_op_e            op_sel;
    logic [WIDTH:0]       row;
    logic                 row_neg;
    logic [2*WIDTH-1:0]   row_ext;
    logic [2*WIDTH-1:0]   row_shifted;
    logic [2*WIDTH-1:0]   addend;

    assign accept   = in_valid && (state_reg == IDLE);
    assign last_row = (cnt_reg == CW'(N-1));

    // b[-1] = 0 sits below the captured multiplier
    assign b_ext   = {b_reg, 1'b0};
    assign shamt   = {cnt_reg, 1'b0};
    assign triplet = b_ext[shamt +: 3];
    assign op_sel  = booth_enc(triplet);

    booth_r4_pp_row #(
        .WIDTH (WIDTH)
    ) u_pp_row (
        .a       (a_reg),
        .op      (op_sel),
        .row     (row),
        .row_neg (row_neg)
    );

    assign row_ext     = {{(WIDTH-1){row_neg}}, row};
    assign row_shifted = row_ext << shamt;

`ifdef BOOTH_APPROX_EN
    logic [KW-1:0]      k_reg;
    logic [2*WIDTH-1:0] row_mask;

    // Column gi survives only when it is at or above the captured k
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_mask
        assign row_mask[gi] = (int'(k_reg) <= gi);
    end

    assign addend = row_shifted & row_mask;
`else
    assign addend = row_shifted;
`endif

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
`ifdef BOOTH_APPROX_EN
            k_reg     <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= a_in;
                b_reg   <= b_in;
                cnt_reg <= '0;
                acc_reg <= '0;
`ifdef BOOTH_APPROX_EN
                k_reg   <= trunc_k;
`endif
            end else if (state_reg == RUN) begin
                acc_reg <= acc_reg + addend;
                cnt_reg <= last_row ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    assign prod = acc_reg;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed, table-driven bench for booth_r4_seq_mult (WIDTH=8), with hand-written
// sequences for DONE back-pressure and reset in the middle of RUN.
module tb_booth_r4_seq_mult;

    localparam int WIDTH = 8;
    localparam int KW    = $clog2(2*WIDTH) + 1;
    localparam int N     = WIDTH / 2;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   a_in      = '0;
    logic [WIDTH-1:0]   b_in      = '0;
    logic [KW-1:0]      trunc_k   = '0;
    logic               in_ready;
    logic               out_valid;
    logic [2*WIDTH-1:0] prod;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int a;
        int b;
        int k;
        int exp;
    } vec_t;

    vec_t vecs[16];
    int   n_vec;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef BOOTH_APPROX_EN
        .trunc_k   (trunc_k),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge with
    // the input bus scrambled so later changes cannot leak into the result.
    task automatic start_op(input int a, input int b, input int k);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_accept", int'(in_ready), 1);
        a_in     = WIDTH'(a);
        b_in     = WIDTH'(b);
        trunc_k  = KW'(k);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = 8'h5A;
        b_in     = 8'hA5;
        trunc_k  = ~trunc_k;
    endtask

    task automatic wait_done(output int lat, output int ready_hi);
        lat      = 0;
        ready_hi = 0;
        while (!out_valid && lat < 50) begin
            if (in_ready) ready_hi++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_release", int'(out_valid), 0);
        check("in_ready_after_release", int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        int ready_hi;
        int stray;

        n_vec = 0;
        vecs[n_vec++] = '{a:    5, b:    3, k: 0, exp:     15};
        vecs[n_vec++] = '{a: -128, b: -128, k: 0, exp:  16384};
        vecs[n_vec++] = '{a:  127, b: -128, k: 0, exp: -16256};
        vecs[n_vec++] = '{a:   -3, b:    7, k: 0, exp:    -21};
        vecs[n_vec++] = '{a:    0, b: -128, k: 0, exp:      0};
        vecs[n_vec++] = '{a:   -1, b:   -1, k: 0, exp:      1};
        vecs[n_vec++] = '{a:  127, b:  127, k: 0, exp:  16129};
        vecs[n_vec++] = '{a: -128, b:  127, k: 0, exp: -16256};
        vecs[n_vec++] = '{a:   -7, b:   -9, k: 0, exp:     63};
        vecs[n_vec++] = '{a:   85, b:  -86, k: 0, exp:  -7310};
`ifdef BOOTH_APPROX_EN
        vecs[n_vec++] = '{a:    5, b:    3, k:  2, exp:  12};
        vecs[n_vec++] = '{a:    5, b:    3, k: 16, exp:   0};
        vecs[n_vec++] = '{a:    5, b:    3, k: 31, exp:   0};
        vecs[n_vec++] = '{a:   -7, b:    5, k:  3, exp: -40};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_prod", int'($signed(prod)), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < n_vec; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].k);
            wait_done(lat, ready_hi);
            check("latency", lat, N);
            check("in_ready_high_in_run", ready_hi, 0);
            check("prod", int'($signed(prod)), vecs[i].exp);
            $display("vec %0d: a=%0d b=%0d k=%0d prod=%0d exp=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].k, $signed(prod), vecs[i].exp, lat);
            finish_op();
        end

        // Back-pressure in DONE: output holds, in_valid pulses are not taken
        start_op(5, 3, 0);
        wait_done(lat, ready_hi);
        check("hold_latency", lat, N);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            a_in     = WIDTH'(c + 9);
            b_in     = WIDTH'(c + 11);
            @(posedge clk); #1;
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_prod", int'($signed(prod)), 15);
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        finish_op();
        stray = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) stray++;
        end
        check("no_queued_op", stray, 0);
        $display("hold: prod=15 held 5 cycles, released");

        // Reset during the second RUN cycle, accumulator already non-zero
        start_op(100, 7, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_prod", int'($signed(prod)), 0);
        check("midrun_reset_out_valid", int'(out_valid), 0);
        check("midrun_reset_in_ready", int'(in_ready), 1);
        stray = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        check("midrun_no_out_valid", stray, 0);
        start_op(-3, 7, 0);
        wait_done(lat, ready_hi);
        check("post_reset_latency", lat, N);
        check("post_reset_prod", int'($signed(prod)), -21);
        $display("reset: post-reset a=-3 b=7 prod=%0d", $signed(prod));
        finish_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
